trig_lut_unit: RTL and testbench

Sine/cosine responder that produces the `sinRead`/`cosRead` operands consumed by the vector ALU elements for the SIN (4'b1011) and COS (4'b1100) operations. It takes an angle over a valid/ready request handshake and looks up both results in a single-port, registered-read quarter-wave ROM. It folds the result into the correct quadrant and returns both values together with a one-cycle `resp_valid` pulse. Outputs hold until the next response, so the ALU can read them as steady operands.

---
 rtl/trig_lut_unit.sv | 134 +++++++++++++
 tb/tb_trig_lut_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/trig_lut_unit.sv
// trig_lut_unit: sine/cosine responder backed by a single-port, registered-read quarter-wave ROM.
// sin and cos are read back to back, folded into their quadrant and returned together.
module trig_lut_unit #(
    parameter int N         = 24,
    parameter int FRAC      = 16,
    parameter int DEPTH     = 256,
    parameter     INIT_FILE = "sin_quarter.hex"
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] angle,
    output logic         resp_valid,
    output logic [N-1:0] sinRead,
    output logic [N-1:0] cosRead
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int ANG_W = IDX_W + 2;
    localparam int MAG_W = FRAC + 1;
    localparam logic [MAG_W-1:0] ONE = {1'b1, {FRAC{1'b0}}};

    // Table contents are computed at elaboration with the same rounding the hex image uses.
    localparam init_file_unused = INIT_FILE;

    typedef enum logic [1:0] {IDLE, RD_SIN, RD_COS, WB} state_t;

    state_t                     state_q, state_d;
    logic        [ANG_W-1:0]    ang_q, ang_d;
    logic        [ANG_W-1:0]    ang_cos;
    logic signed [N-1:0]        hold_q, hold_d;
    logic signed [N-1:0]        sin_q, sin_d;
    logic signed [N-1:0]        cos_q, cos_d;
    logic                       vld_q, vld_d;
    logic        [IDX_W-1:0]    rom_addr;
    logic        [MAG_W-1:0]    rom_q;
    logic        [MAG_W-1:0]    rom_tbl [DEPTH];
    logic        [N-ANG_W-1:0]  angle_hi_unused;

    // Taylor series of sin(k*pi/(2*DEPTH)) in Q30 fixed point, rounded to Q.FRAC.
    function automatic logic [MAG_W-1:0] sin_word(input int k);
        longint x, x2, term, acc;
        x    = (longint'(k) * 64'sd1686629713) / longint'(DEPTH);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        return MAG_W'((acc + (longint'(1) <<< (29 - FRAC))) >>> (30 - FRAC));
    endfunction

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [MAG_W-1:0] WORD = sin_word(k);
        assign rom_tbl[k] = WORD;
    end

    // Odd quadrants read the table backwards; DEPTH-r wraps to 0 when r=0, which is never used.
    function automatic logic [IDX_W-1:0] rom_index(input logic [ANG_W-1:0] a);
        return a[ANG_W-2] ? IDX_W'(0) - a[IDX_W-1:0] : a[IDX_W-1:0];
    endfunction

    function automatic logic signed [N-1:0] fold_val(input logic [ANG_W-1:0] a,
                                                     input logic [MAG_W-1:0] word);
        logic signed [N-1:0] mag;
        mag = (a[ANG_W-2] && (a[IDX_W-1:0] == '0)) ? N'(ONE) : N'(word);
        return a[ANG_W-1] ? -mag : mag;
    endfunction

    assign angle_hi_unused = angle[N-1:ANG_W];
    assign ang_cos         = ang_q + ANG_W'(DEPTH);
    assign resp_valid      = vld_q;
    assign sinRead         = sin_q;
    assign cosRead         = cos_q;

    always_comb begin
        state_d   = state_q;
        ang_d     = ang_q;
        hold_d    = hold_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        vld_d     = 1'b0;
        rom_addr  = '0;
        req_ready = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ang_d   = angle[ANG_W-1:0];
                    state_d = RD_SIN;
                end
            end
            RD_SIN: begin
                rom_addr = rom_index(ang_q);
                state_d  = RD_COS;
            end
            RD_COS: begin
                rom_addr = rom_index(ang_cos);
                hold_d   = fold_val(ang_q, rom_q);
                state_d  = WB;
            end
            WB: begin
                sin_d   = hold_q;
                cos_d   = fold_val(ang_cos, rom_q);
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ang_q   <= '0;
            hold_q  <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ang_q   <= ang_d;
            hold_q  <= hold_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        rom_q <= rom_tbl[rom_addr];
    end

endmodule

// File: tb/tb_trig_lut_unit.sv
// Self-checking bench for trig_lut_unit: directed axis/handshake cases plus a randomized full sweep
// against a real-valued sin/cos model.
module tb_trig_lut_unit;
    localparam int N = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] angle;
    logic         resp_valid;
    logic [N-1:0] sinRead;
    logic [N-1:0] cosRead;

    int total = 0;
    int bad   = 0;

    int sin_tbl [1024];
    int cos_tbl [1024];

    logic [N-1:0] d_ang [8] = '{24'd0, 24'd256, 24'd512, 24'd768, 24'd128, 24'd640, 24'h000480, 24'hABC080};
    logic [N-1:0] d_sin [8] = '{24'h000000, 24'h010000, 24'h000000, 24'hFF0000, 24'h00B505, 24'hFF4AFB, 24'h00B505, 24'h00B505};
    logic [N-1:0] d_cos [8] = '{24'h010000, 24'h000000, 24'hFF0000, 24'h000000, 24'h00B505, 24'hFF4AFB, 24'h00B505, 24'h00B505};

    always #5 clk = ~clk;

    trig_lut_unit #(.N(24), .FRAC(16), .DEPTH(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .angle      (angle),
        .resp_valid (resp_valid),
        .sinRead    (sinRead),
        .cosRead    (cosRead)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint obs, input longint exp, input longint tol);
        total++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    // Real-valued reference: round(f(2*pi*a/1024) * 2^16).
    function automatic int model_trig(input int a, input bit is_cos);
        real ph, v;
        ph = 2.0 * 3.14159265358979323846 * real'(a % 1024) / 1024.0;
        v  = (is_cos ? $cos(ph) : $sin(ph)) * 65536.0;
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // Issue one request; optionally scramble angle and pulse req_valid while busy.
    task automatic run_req(input logic [N-1:0] a, input bit disturb,
                           output logic [N-1:0] s, output logic [N-1:0] c);
        int cyc;
        logic [N-1:0] junk;
        @(negedge clk);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        angle     = a;
        @(negedge clk);
        req_valid = 1'b0;
        check("ready_busy", req_ready, 0);
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 12) begin
            if (disturb) begin
                junk      = N'($urandom);
                angle     = junk;
                req_valid = (cyc == 2);
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        check("latency", cyc, 4);
        s = sinRead;
        c = cosRead;
    endtask

    initial begin
        logic [N-1:0] s, c;
        int seen, pat_bad, pulses;
        logic [13:0] hi;
        longint si, ci;

        rst       = 1'b1;
        req_valid = 1'b0;
        angle     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_sin", sinRead, 0);
        check("rst_cos", cosRead, 0);

        // Reset while the request sits in RD_COS must abort it silently.
        @(negedge clk);
        req_valid = 1'b1;
        angle     = 24'd256;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", req_ready, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid !== 1'b0 || sinRead !== '0 || cosRead !== '0) seen++;
            @(negedge clk);
        end
        check("abort_quiet", seen, 0);

        for (int i = 0; i < 8; i++) begin
            run_req(d_ang[i], 1'b0, s, c);
            check($sformatf("dir_sin_%0h", d_ang[i]), s, d_sin[i]);
            check($sformatf("dir_cos_%0h", d_ang[i]), c, d_cos[i]);
        end

        // Busy-time angle changes and a dropped pulse must leave no trace.
        run_req(24'd384, 1'b1, s, c);
        check("drop_sin", s, 24'h00B505);
        check("drop_cos", c, 24'hFF4AFB);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        check("drop_no_extra_resp", seen, 0);

        // req_valid held high: accepts every 4 cycles, responses 3 cycles after each.
        @(negedge clk);
        angle     = 24'd640;
        req_valid = 1'b1;
        pat_bad   = 0;
        pulses    = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 12) req_valid = 1'b0;
            if (resp_valid !== ((i % 4) == 0)) pat_bad++;
            if (resp_valid === 1'b1) pulses++;
        end
        check("held_pattern_errs", pat_bad, 0);
        check("held_pulses", pulses, 3);
        check("held_sin", sinRead, 24'hFF4AFB);
        check("held_cos", cosRead, 24'hFF4AFB);

        for (int a = 0; a < 1024; a++) begin
            hi = 14'($urandom);
            run_req({hi, 10'(a)}, 1'($urandom), s, c);
            si = longint'($signed(s));
            ci = longint'($signed(c));
            sin_tbl[a] = int'(si);
            cos_tbl[a] = int'(ci);
            check_near($sformatf("sweep_sin_%0d", a), si, model_trig(a, 1'b0), 1);
            check_near($sformatf("sweep_cos_%0d", a), ci, model_trig(a, 1'b1), 1);
            check_near($sformatf("sweep_pyth_%0d", a), si * si + ci * ci, 64'd4294967296, 4 * 65536);
        end
        for (int a = 0; a < 1024; a++) begin
            check($sformatf("cos_shift_%0d", a), cos_tbl[a], sin_tbl[(a + 256) % 1024]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
